sample_packetizer: RTL and testbench
====================================

Name: sample_packetizer

Overview:
- Upstream feeder for the SPI master transmitter.
- Accepts 16-bit audio samples from the capture path and buffers them in a small FIFO.
- Emits fixed-length byte packets over a valid/ready byte interface: header byte, N samples MSB-byte-first, then an XOR checksum byte.
- The SPI master consumes one byte per handshake and keeps CS/SCLK framing to itself.

Parameters:
- SAMPLE_W, 16, sample width; fixed at 16, split into 2 bytes.
- FIFO_DEPTH, 16, sample FIFO entries; power of two, ≥ SAMPLES_PER_PKT.
- SAMPLES_PER_PKT, 4, samples per packet (N); range 1..FIFO_DEPTH.
- HEADER_BYTE, 8'hA5, sync byte sent first in every packet.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- s_data  in  16  sample from capture path.
- s_valid  in  1  one-cycle push strobe for s_data.
- ovf_clr  in  1  clears sticky overflow flag.
- tx_data  out  8  byte offered to the SPI master.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  SPI master accepts tx_data this cycle.
- fifo_level  out  5  samples currently held (0..FIFO_DEPTH), clog2(FIFO_DEPTH)+1 bits.
- overflow  out  1  sticky: a sample was dropped.
- busy  out  1  high whenever FSM is not IDLE.

Behaviour:
- Reset (rst low, async) clears all state immediately:
  - tx_valid=0, tx_data=0, fifo_level=0, overflow=0, busy=0.
  - FSM to IDLE; checksum and sample counter cleared.
  - FIFO contents are discarded. Reset mid-packet abandons the packet and sends no trailer.
- FIFO behaviour:
  - Push occurs when s_valid=1 and (not full, or a pop happens in the same cycle).
  - Pop occurs when a LO byte handshakes.
  - Simultaneous push+pop leaves fifo_level unchanged.
  - Push while full with no pop drops the sample and sets overflow=1.
  - overflow clears only on ovf_clr=1. If ovf_clr and a drop occur in the same cycle, overflow stays 1.
  - Pointers wrap modulo FIFO_DEPTH.
- Handshake:
  - A byte transfers on a rising edge where tx_valid=1 and tx_ready=1.
  - While tx_valid=1 and tx_ready=0, tx_data is held stable.
  - tx_valid never drops without a transfer, except on reset.
  - tx_valid and tx_data are registered outputs.
- FSM states (enum): IDLE, HDR, HI, LO, CSUM.
  - IDLE: tx_valid=0. If registered fifo_level ≥ SAMPLES_PER_PKT, go to HDR with tx_data=HEADER_BYTE and tx_valid=1 on that edge. This gives one cycle of latency after the push edge that reaches level N.
  - HDR: on transfer go to HI, tx_data=head[15:8]. Clear checksum and sample counter.
  - HI: on transfer go to LO, tx_data=head[7:0]. checksum ^= head[15:8].
  - LO: on transfer pop the FIFO, checksum ^= head[7:0], increment sample counter.
    - If counter reaches SAMPLES_PER_PKT-1 before the increment, go to CSUM with tx_data = updated checksum.
    - Otherwise go to HI with the next head's high byte.
  - CSUM: on transfer go to IDLE with tx_valid=0.
- Back-to-back packets:
  - IDLE always costs at least one cycle between CSUM transfer and the next HDR (one dead cycle).
  - Packet content is fixed once started, because FIFO entries only leave via pop.
- Checksum: 8-bit XOR of the 2N payload bytes; the header is excluded.
- busy = (state != IDLE).
- Pushes continue to be accepted during packet transmission.

Decomposition:
- Package shazam_spi_pkg:
  - pkt_state_t enum (IDLE, HDR, HI, LO, CSUM).
  - HEADER_BYTE default constant.
  - Byte-width localparam.
- Sub-module sync_fifo (parameterised width/depth):
  - Ports: push, pop, wdata, rdata (show-ahead head), level, full, empty.
  - Instantiated once with width 16.
- Packetizer FSM, checksum and overflow flag live in sample_packetizer.

Test Plan:
1. Push 0x1234, 0xABCD, 0x0001, 0xFF00 with tx_ready=1 constantly -> tx bytes A5,12,34,AB,CD,00,01,FF,00,BE in consecutive cycles; fifo_level returns to 0; busy low after CSUM.
2. Push 3 samples, wait 20 cycles -> tx_valid stays 0 and fifo_level=3. Push 4th -> tx_valid=1 with 0xA5 two edges after the 4th push strobe.
3. Same data as test 1; hold tx_ready=0 for 5 cycles while tx_data=0xAB -> tx_data stays 0xAB and tx_valid stays 1; after ready, exactly one 0xAB is transferred, no duplicate; checksum still 0xBE.
4. Hold tx_ready=0 and push 17 samples -> fifo_level=16 and overflow=1. Pulse ovf_clr -> overflow=0. The dropped 17th sample never appears on tx_data.
5. FIFO full at 16 and state LO, assert s_valid together with the LO transfer -> fifo_level stays 16 and overflow stays 0.
6. Assert rst low mid-packet, after the 0x34 byte -> tx_valid=0 immediately (async), fifo_level=0, overflow=0. After release, no tx_valid until 4 new samples; then a fresh packet starting 0xA5.

Source files
------------

// File: rtl/shazam_spi_pkg.sv
// Shared types and constants for the sample packetizer feeding the SPI master.
package shazam_spi_pkg;

    localparam int unsigned BYTE_W          = 8;
    localparam logic [7:0]  HEADER_BYTE_DEF = 8'hA5;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        HI   = 3'd2,
        LO   = 3'd3,
        CSUM = 3'd4
    } pkt_state_t;

    // Upper byte of a 16-bit sample, sent first on the wire.
    function automatic logic [BYTE_W-1:0] sample_hi(input logic [15:0] s);
        return s[15:8];
    endfunction

    // Lower byte of a 16-bit sample, sent second on the wire.
    function automatic logic [BYTE_W-1:0] sample_lo(input logic [15:0] s);
        return s[7:0];
    endfunction

endpackage

// File: rtl/sample_packetizer_sync_fifo.sv
// Synchronous show-ahead FIFO. Exposes the head entry and the entry behind it,
// so a consumer can load the follower in the same cycle it pops the head.
module sync_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [WIDTH-1:0] rdata_next_o,
    output logic [AW:0]      level_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             do_push;
    logic             do_pop;

    assign full_o       = (level_q == (AW+1)'(DEPTH));
    assign empty_o      = (level_q == '0);
    assign level_o      = level_q;
    assign rdata_o      = mem_q[rd_ptr_q];
    assign rdata_next_o = mem_q[rd_ptr_q + AW'(1)];

    // Qualify requests and compute next pointers and occupancy.
    always_comb begin
        do_pop   = pop_i && !empty_o;
        do_push  = push_i && (!full_o || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer and occupancy registers; reset discards the stored contents.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; no reset needed since pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/sample_packetizer.sv
// Buffers 16-bit audio samples and emits fixed-length byte packets
// (header, N samples MSB-byte-first, XOR checksum) to the SPI master.
module sample_packetizer
    import shazam_spi_pkg::*;
#(
    parameter int unsigned SAMPLE_W        = 16,
    parameter int unsigned FIFO_DEPTH      = 16,
    parameter int unsigned SAMPLES_PER_PKT = 4,
    parameter logic [7:0]  HEADER_BYTE     = HEADER_BYTE_DEF,
    localparam int unsigned LVL_W          = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] s_data,
    input  logic                s_valid,
    input  logic                ovf_clr,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic [LVL_W-1:0]    fifo_level,
    output logic                overflow,
    output logic                busy
);

    pkt_state_t          state_q, state_d;
    logic [7:0]          tx_data_q, tx_data_d;
    logic                tx_valid_q, tx_valid_d;
    logic [7:0]          csum_q, csum_d;
    logic [LVL_W-1:0]    cnt_q, cnt_d;
    logic                ovf_q, ovf_d;

    logic [SAMPLE_W-1:0] head;
    logic [SAMPLE_W-1:0] head_next;
    logic [LVL_W-1:0]    level;
    logic                fifo_full;
    logic                fifo_empty;
    logic                pop;
    logic                xfer;
    logic                drop;

    sync_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (s_valid),
        .pop_i        (pop),
        .wdata_i      (s_data),
        .rdata_o      (head),
        .rdata_next_o (head_next),
        .level_o      (level),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty)
    );

    assign xfer       = tx_valid_q && tx_ready;
    assign drop       = s_valid && fifo_full && !pop;
    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign fifo_level = level;
    assign overflow   = ovf_q;
    assign busy       = (state_q != IDLE);

    // Packet sequencer: every branch advances only on a byte transfer, so the
    // offered byte is held until the SPI master takes it.
    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        csum_d     = csum_q;
        cnt_d      = cnt_q;
        pop        = 1'b0;
        unique case (state_q)
            IDLE: begin
                tx_valid_d = 1'b0;
                if (level >= LVL_W'(SAMPLES_PER_PKT)) begin
                    state_d    = HDR;
                    tx_data_d  = HEADER_BYTE;
                    tx_valid_d = 1'b1;
                end
            end
            HDR: begin
                if (xfer) begin
                    state_d   = HI;
                    tx_data_d = sample_hi(head);
                    csum_d    = '0;
                    cnt_d     = '0;
                end
            end
            HI: begin
                if (xfer) begin
                    state_d   = LO;
                    tx_data_d = sample_lo(head);
                    csum_d    = csum_q ^ sample_hi(head);
                end
            end
            LO: begin
                if (xfer) begin
                    pop    = !fifo_empty;
                    csum_d = csum_q ^ sample_lo(head);
                    cnt_d  = cnt_q + LVL_W'(1);
                    if (cnt_q == LVL_W'(SAMPLES_PER_PKT - 1)) begin
                        state_d   = CSUM;
                        tx_data_d = csum_q ^ sample_lo(head);
                    end else begin
                        // The head is popped on this edge, so the next high
                        // byte must come from the entry behind it.
                        state_d   = HI;
                        tx_data_d = sample_hi(head_next);
                    end
                end
            end
            CSUM: begin
                if (xfer) begin
                    state_d    = IDLE;
                    tx_valid_d = 1'b0;
                end
            end
            default: begin
                state_d    = IDLE;
                tx_valid_d = 1'b0;
            end
        endcase
    end

    // Sticky overflow: a drop in the same cycle as a clear wins.
    always_comb begin
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    // Sequencer, output byte, checksum and overflow registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
            csum_q     <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            csum_q     <= csum_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
        end
    end

endmodule

// File: tb/tb_sample_packetizer.sv
// Self-checking bench for sample_packetizer: scenario tasks plus a packet
// reference built from the list of accepted samples.
module tb_sample_packetizer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] s_data;
    logic        s_valid;
    logic        ovf_clr;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [4:0]  fifo_level;
    logic        overflow;
    logic        busy;

    int          checks   = 0;
    int          failures = 0;
    int unsigned cyc      = 0;

    logic [7:0]  rx_q  [$];
    int unsigned rx_t  [$];
    logic [15:0] smp_q [$];
    logic [7:0]  exp_q [$];

    logic        stall_q = 1'b0;
    logic [7:0]  stall_data;

    sample_packetizer #(
        .SAMPLE_W        (16),
        .FIFO_DEPTH      (16),
        .SAMPLES_PER_PKT (4),
        .HEADER_BYTE     (8'hA5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .ovf_clr    (ovf_clr),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .fifo_level (fifo_level),
        .overflow   (overflow),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Byte monitor at the falling edge: records what the next rising edge
    // transfers, and checks a stalled byte is still offered unchanged.
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (stall_q) begin
                checks++;
                if (tx_valid !== 1'b1 || tx_data !== stall_data) begin
                    failures++;
                    $display("FAIL hold_stable got valid=%b data=%h exp valid=1 data=%h",
                             tx_valid, tx_data, stall_data);
                end
            end
            if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
                rx_q.push_back(tx_data);
                rx_t.push_back(cyc);
            end
            stall_q    = (tx_valid === 1'b1 && tx_ready === 1'b0);
            stall_data = tx_data;
        end else begin
            stall_q = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    // Expected wire bytes for every complete group of 4 samples.
    function automatic void build_exp();
        logic [7:0]  cs;
        logic [15:0] s;
        exp_q.delete();
        for (int p = 0; p < smp_q.size() / 4; p++) begin
            cs = 8'h00;
            exp_q.push_back(8'hA5);
            for (int k = 0; k < 4; k++) begin
                s = smp_q[p*4 + k];
                exp_q.push_back(s[15:8]);
                exp_q.push_back(s[7:0]);
                cs = cs ^ s[15:8] ^ s[7:0];
            end
            exp_q.push_back(cs);
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_sample(input logic [15:0] d);
        s_data  = d;
        s_valid = 1'b1;
        step();
        s_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        s_valid  = 1'b0;
        ovf_clr  = 1'b0;
        tx_ready = 1'b0;
        s_data   = '0;
        step();
        step();
        rst = 1'b1;
        step();
        rx_q.delete();
        rx_t.delete();
        smp_q.delete();
    endtask

    task automatic drain(input int n, output bit ok);
        tx_ready = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (rx_q.size() >= n) break;
            step();
        end
        ok = (rx_q.size() >= n);
        repeat (4) step();
    endtask

    task automatic test_reset();
        rst      = 1'b0;
        s_valid  = 1'b0;
        ovf_clr  = 1'b0;
        tx_ready = 1'b0;
        s_data   = '0;
        step();
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
        checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
        checks++; if (fifo_level !== 5'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst = 1'b1;
        step();
    endtask

    task automatic test_basic();
        logic [15:0] vals [4];
        logic [7:0]  got;
        bit          ok;
        bit          consec;
        vals = '{16'h1234, 16'hABCD, 16'h0001, 16'hFF00};
        do_reset();
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_sample(vals[i]);
            smp_q.push_back(vals[i]);
        end
        build_exp();
        drain(10, ok);
        checks++;
        if (!ok || rx_q.size() != exp_q.size()) begin
            failures++; $display("FAIL basic_len got=%0d exp=%0d", rx_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
            checks++;
            if (got !== exp_q[i]) begin failures++; $display("FAIL basic_byte[%0d] got=%h exp=%h", i, got, exp_q[i]); end
        end
        got = (rx_q.size() > 9) ? rx_q[9] : 8'hxx;
        checks++; if (got !== 8'hBE) begin failures++; $display("FAIL basic_csum got=%h exp=be", got); end
        consec = (rx_t.size() == 10);
        for (int i = 1; i < rx_t.size(); i++) if (rx_t[i] != rx_t[0] + i) consec = 1'b0;
        checks++; if (!consec) begin failures++; $display("FAIL basic_consecutive got=0 exp=1"); end
        checks++; if (fifo_level !== 5'd0) begin failures++; $display("FAIL basic_level got=%0d exp=0", fifo_level); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy got=%b exp=0", busy); end
    endtask

    task automatic test_threshold();
        logic [15:0] d;
        logic [7:0]  got;
        bit          seen;
        bit          ok;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            d = 16'($urandom);
            push_sample(d);
            smp_q.push_back(d);
        end
        seen = 1'b0;
        repeat (20) begin
            step();
            if (tx_valid !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen) begin failures++; $display("FAIL thr_early_valid got=1 exp=0"); end
        checks++; if (fifo_level !== 5'd3) begin failures++; $display("FAIL thr_level got=%0d exp=3", fifo_level); end
        d       = 16'($urandom);
        s_data  = d;
        s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        smp_q.push_back(d);
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL thr_edge1_valid got=%b exp=0", tx_valid); end
        step();
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
            failures++; $display("FAIL thr_edge2 got valid=%b data=%h exp valid=1 data=a5", tx_valid, tx_data);
        end
        build_exp();
        drain(10, ok);
        checks++;
        if (!ok || rx_q.size() != exp_q.size()) begin
            failures++; $display("FAIL thr_len got=%0d exp=%0d", rx_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
            checks++;
            if (got !== exp_q[i]) begin failures++; $display("FAIL thr_byte[%0d] got=%h exp=%h", i, got, exp_q[i]); end
        end
    endtask

    task automatic test_stall();
        logic [15:0] vals [4];
        logic [7:0]  got;
        bit          ok;
        bit          found;
        vals = '{16'h1234, 16'hABCD, 16'h0001, 16'hFF00};
        do_reset();
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_sample(vals[i]);
            smp_q.push_back(vals[i]);
        end
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (tx_valid === 1'b1 && tx_data === 8'hAB) begin found = 1'b1; break; end
            step();
        end
        tx_ready = 1'b0;
        checks++; if (!found) begin failures++; $display("FAIL stall_reach_ab got=0 exp=1"); end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (tx_valid !== 1'b1 || tx_data !== 8'hAB) begin
                failures++; $display("FAIL stall_hold[%0d] got valid=%b data=%h exp valid=1 data=ab", i, tx_valid, tx_data);
            end
        end
        build_exp();
        drain(10, ok);
        checks++;
        if (!ok || rx_q.size() != exp_q.size()) begin
            failures++; $display("FAIL stall_len got=%0d exp=%0d", rx_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
            checks++;
            if (got !== exp_q[i]) begin failures++; $display("FAIL stall_byte[%0d] got=%h exp=%h", i, got, exp_q[i]); end
        end
    endtask

    task automatic test_overflow();
        logic [15:0] d;
        logic [7:0]  got;
        bit          ok;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            d = 16'($urandom);
            push_sample(d);
            if (i < 16) smp_q.push_back(d);
        end
        checks++; if (fifo_level !== 5'd16) begin failures++; $display("FAIL ovf_level got=%0d exp=16", fifo_level); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", overflow); end
        s_data  = 16'($urandom);
        s_valid = 1'b1;
        ovf_clr = 1'b1;
        step();
        s_valid = 1'b0;
        ovf_clr = 1'b0;
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_clr_vs_drop got=%b exp=1", overflow); end
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
        build_exp();
        drain(40, ok);
        checks++;
        if (!ok || rx_q.size() != exp_q.size()) begin
            failures++; $display("FAIL ovf_len got=%0d exp=%0d", rx_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
            checks++;
            if (got !== exp_q[i]) begin failures++; $display("FAIL ovf_byte[%0d] got=%h exp=%h", i, got, exp_q[i]); end
        end
        checks++; if (fifo_level !== 5'd0) begin failures++; $display("FAIL ovf_end_level got=%0d exp=0", fifo_level); end
    endtask

    task automatic test_full_pushpop();
        logic [15:0] d;
        logic [7:0]  got;
        bit          ok;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            d = 16'($urandom);
            push_sample(d);
            smp_q.push_back(d);
        end
        checks++; if (tx_valid !== 1'b1 || tx_data !== 8'hA5) begin
            failures++; $display("FAIL full_hdr got valid=%b data=%h exp valid=1 data=a5", tx_valid, tx_data);
        end
        tx_ready = 1'b1;
        step();
        step();
        d       = 16'($urandom);
        s_data  = d;
        s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        smp_q.push_back(d);
        checks++; if (fifo_level !== 5'd16) begin failures++; $display("FAIL full_pp_level got=%0d exp=16", fifo_level); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL full_pp_overflow got=%b exp=0", overflow); end
        build_exp();
        drain(40, ok);
        checks++;
        if (!ok || rx_q.size() != exp_q.size()) begin
            failures++; $display("FAIL full_len got=%0d exp=%0d", rx_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
            checks++;
            if (got !== exp_q[i]) begin failures++; $display("FAIL full_byte[%0d] got=%h exp=%h", i, got, exp_q[i]); end
        end
        checks++; if (fifo_level !== 5'd1) begin failures++; $display("FAIL full_end_level got=%0d exp=1", fifo_level); end
    endtask

    task automatic test_reset_mid();
        logic [15:0] vals [4];
        logic [15:0] d;
        logic [7:0]  got;
        bit          ok;
        bit          seen;
        vals = '{16'h1234, 16'hABCD, 16'h0001, 16'hFF00};
        do_reset();
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) push_sample(vals[i]);
        for (int i = 0; i < 50; i++) begin
            if (rx_q.size() >= 3) break;
            step();
        end
        got = (rx_q.size() >= 3) ? rx_q[2] : 8'hxx;
        checks++; if (got !== 8'h34) begin failures++; $display("FAIL mid_third_byte got=%h exp=34", got); end
        rst = 1'b0;
        #1;
        checks++; if (tx_valid !== 1'b0) begin failures++; $display("FAIL mid_async_valid got=%b exp=0", tx_valid); end
        checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL mid_async_data got=%h exp=00", tx_data); end
        checks++; if (fifo_level !== 5'd0) begin failures++; $display("FAIL mid_async_level got=%0d exp=0", fifo_level); end
        checks++; if (overflow !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL mid_async_flags got ovf=%b busy=%b exp 0 0", overflow, busy);
        end
        step();
        step();
        rst = 1'b1;
        step();
        rx_q.delete();
        rx_t.delete();
        smp_q.delete();
        for (int i = 0; i < 3; i++) begin
            d = 16'($urandom);
            push_sample(d);
            smp_q.push_back(d);
        end
        seen = 1'b0;
        repeat (10) begin
            step();
            if (tx_valid !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen || rx_q.size() != 0) begin
            failures++; $display("FAIL mid_quiet got valid_seen=%b bytes=%0d exp 0 0", seen, rx_q.size());
        end
        d = 16'($urandom);
        push_sample(d);
        smp_q.push_back(d);
        build_exp();
        drain(10, ok);
        checks++;
        if (!ok || rx_q.size() != exp_q.size()) begin
            failures++; $display("FAIL mid_len got=%0d exp=%0d", rx_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
            checks++;
            if (got !== exp_q[i]) begin failures++; $display("FAIL mid_byte[%0d] got=%h exp=%h", i, got, exp_q[i]); end
        end
    endtask

    task automatic test_random();
        logic [15:0] d;
        logic [7:0]  got;
        bit          ok;
        int          outstanding;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            tx_ready    = ($urandom_range(0, 9) < 7);
            outstanding = smp_q.size() - 4 * (rx_q.size() / 10);
            if (outstanding < 12 && $urandom_range(0, 9) < 4) begin
                d       = 16'($urandom);
                s_data  = d;
                s_valid = 1'b1;
                smp_q.push_back(d);
            end else begin
                s_valid = 1'b0;
            end
            step();
        end
        s_valid = 1'b0;
        build_exp();
        drain(exp_q.size(), ok);
        checks++;
        if (!ok || rx_q.size() != exp_q.size()) begin
            failures++; $display("FAIL rand_len got=%0d exp=%0d", rx_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < rx_q.size()) ? rx_q[i] : 8'hxx;
            checks++;
            if (got !== exp_q[i]) begin failures++; $display("FAIL rand_byte[%0d] got=%h exp=%h", i, got, exp_q[i]); end
        end
        checks++; if (fifo_level !== 5'(smp_q.size() % 4)) begin
            failures++; $display("FAIL rand_level got=%0d exp=%0d", fifo_level, smp_q.size() % 4);
        end
        checks++; if (overflow !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL rand_flags got ovf=%b busy=%b exp 0 0", overflow, busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_threshold();
        test_stall();
        test_overflow();
        test_full_pushpop();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
